// File: rtl/batcharger_ctrl_fsm.sv
// Battery charger sequencer: trickle / constant-current / constant-voltage charge
// with debounced threshold transitions, charge timers and temperature protection.
//
// state   | meaning
// --------+----------------------------------------------
// S_IDLE  | charger off, qualifying enable and battery state
// S_TC    | trickle charge at itc, bounded by TTC_MAX
// S_CC    | constant current at icc
// S_CV    | constant voltage at vpreset, current-limited to icc
// S_DONE  | charge complete, watching for recharge threshold
// S_FAULT | temperature out of window or trickle timeout
module batcharger_ctrl_fsm #(
    parameter int DEB     = 4,
    parameter int TTC_MAX = 500,
    parameter int TCV_MAX = 1000,
    parameter int RECH    = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] vbat,
    input  logic [7:0] ibat,
    input  logic [7:0] vtemp,
    input  logic [7:0] tempmin,
    input  logic [7:0] tempmax,
    input  logic [7:0] vcutoff,
    input  logic [7:0] vpreset,
    input  logic [7:0] itc,
    input  logic [7:0] icc,
    input  logic [7:0] iend,
    output logic       tc,
    output logic       cc,
    output logic       cv,
    output logic [7:0] idac,
    output logic [7:0] vdac,
    output logic       done,
    output logic       fault
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TC    = 3'd1,
        S_CC    = 3'd2,
        S_CV    = 3'd3,
        S_DONE  = 3'd4,
        S_FAULT = 3'd5
    } state_t;

    localparam logic [2:0]  DEB_LAST = 3'(DEB - 1);
    localparam logic [15:0] TTC_LAST = 16'(TTC_MAX - 1);
    localparam logic [15:0] TCV_LAST = 16'(TCV_MAX - 1);
    localparam logic [7:0]  RECH_L   = 8'(RECH);

    state_t      state_q, state_d;
    logic [2:0]  deb_q, deb_d;
    logic [15:0] tmr_q, tmr_d;
    logic        tc_q, tc_d, cc_q, cc_d, cv_q, cv_d, done_q, done_d, fault_q, fault_d;
    logic [7:0]  idac_q, idac_d, vdac_q, vdac_d;

    logic        temp_ok;
    logic [7:0]  rech_thr;
    logic        cond;
    state_t      target;
    logic        timeout;

    always_comb begin
        temp_ok  = (vtemp >= tempmin) && (vtemp <= tempmax);
        rech_thr = (vpreset >= RECH_L) ? (vpreset - RECH_L) : 8'd0;
        cond     = 1'b0;
        target   = state_q;
        timeout  = 1'b0;
        case (state_q)
            S_IDLE: begin
                cond = en;
                if (!temp_ok)              target = S_FAULT;
                else if (vbat < vcutoff)   target = S_TC;
                else if (vbat < vpreset)   target = S_CC;
                else                       target = S_CV;
            end
            S_TC: begin
                cond    = (vbat >= vcutoff);
                target  = S_CC;
                timeout = (tmr_q == TTC_LAST);
            end
            S_CC: begin
                cond   = (vbat >= vpreset);
                target = S_CV;
            end
            S_CV: begin
                cond    = (ibat <= iend);
                target  = S_DONE;
                timeout = (tmr_q == TCV_LAST);
            end
            S_DONE: begin
                cond   = (vbat < rech_thr);
                target = S_CC;
            end
            S_FAULT: begin
                cond   = temp_ok;
                target = S_IDLE;
            end
            default: begin
                cond   = 1'b0;
                target = S_IDLE;
            end
        endcase
    end

    // Timer expiry is undebounced and beats any debounced exit on the same edge.
    always_comb begin
        state_d = state_q;
        if (!en)                                 state_d = S_IDLE;
        else if (!temp_ok && state_q != S_IDLE)  state_d = S_FAULT;
        else if (timeout && state_q == S_TC)     state_d = S_FAULT;
        else if (timeout && state_q == S_CV)     state_d = S_DONE;
        else if (cond && deb_q == DEB_LAST)      state_d = target;

        if (state_d != state_q)  deb_d = 3'd0;
        else if (cond)           deb_d = (deb_q == 3'd7) ? 3'd7 : deb_q + 3'd1;
        else                     deb_d = 3'd0;

        if (state_d != state_q)                    tmr_d = 16'd0;
        else if (state_q == S_TC || state_q == S_CV) tmr_d = tmr_q + 16'd1;
        else                                       tmr_d = 16'd0;
    end

    // Outputs decode the next state so they register on the same edge as it.
    always_comb begin
        tc_d    = 1'b0;
        cc_d    = 1'b0;
        cv_d    = 1'b0;
        done_d  = 1'b0;
        fault_d = 1'b0;
        idac_d  = 8'd0;
        vdac_d  = 8'd0;
        case (state_d)
            S_TC: begin
                tc_d   = 1'b1;
                idac_d = itc;
            end
            S_CC: begin
                cc_d   = 1'b1;
                idac_d = icc;
            end
            S_CV: begin
                cv_d   = 1'b1;
                idac_d = icc;
                vdac_d = vpreset;
            end
            S_DONE:  done_d  = 1'b1;
            S_FAULT: fault_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            deb_q   <= 3'd0;
            tmr_q   <= 16'd0;
            tc_q    <= 1'b0;
            cc_q    <= 1'b0;
            cv_q    <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
            idac_q  <= 8'd0;
            vdac_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            deb_q   <= deb_d;
            tmr_q   <= tmr_d;
            tc_q    <= tc_d;
            cc_q    <= cc_d;
            cv_q    <= cv_d;
            done_q  <= done_d;
            fault_q <= fault_d;
            idac_q  <= idac_d;
            vdac_q  <= vdac_d;
        end
    end

    assign tc    = tc_q;
    assign cc    = cc_q;
    assign cv    = cv_q;
    assign done  = done_q;
    assign fault = fault_q;
    assign idac  = idac_q;
    assign vdac  = vdac_q;

endmodule

// File: tb/tb_batcharger_ctrl_fsm.sv
// Directed bench for batcharger_ctrl_fsm: expected output words are queued as
// stimulus is applied and popped against the DUT one edge at a time.
module tb_batcharger_ctrl_fsm;

    logic       clk = 1'b0;
    logic       rst, en;
    logic [7:0] vbat, ibat, vtemp, tempmin, tempmax, vcutoff, vpreset, itc, icc, iend;
    logic       tc, cc, cv, done, fault;
    logic [7:0] idac, vdac;

    batcharger_ctrl_fsm dut (
        .clk(clk), .rst(rst), .en(en), .vbat(vbat), .ibat(ibat), .vtemp(vtemp),
        .tempmin(tempmin), .tempmax(tempmax), .vcutoff(vcutoff), .vpreset(vpreset),
        .itc(itc), .icc(icc), .iend(iend), .tc(tc), .cc(cc), .cv(cv),
        .idac(idac), .vdac(vdac), .done(done), .fault(fault)
    );

    always #5 clk = ~clk;

    // {tc, cc, cv, done, fault, idac, vdac}
    localparam logic [20:0] O_IDLE  = 21'd0;
    localparam logic [20:0] O_TC    = {5'b10000, 8'd10,  8'd0};
    localparam logic [20:0] O_CC    = {5'b01000, 8'd112, 8'd0};
    localparam logic [20:0] O_CV    = {5'b00100, 8'd112, 8'd210};
    localparam logic [20:0] O_DONE  = {5'b00010, 8'd0,   8'd0};
    localparam logic [20:0] O_FAULT = {5'b00001, 8'd0,   8'd0};

    typedef struct {
        string       tag;
        logic [20:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  n_asserts = 0;
    int  n_fail    = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Queue n identical expectations, then check one per edge.
    task automatic expect_n(input string tag, input logic [20:0] exp, input int n);
        sb_t e;
        logic [20:0] obs;
        for (int i = 0; i < n; i++) begin
            e.tag = tag;
            e.exp = exp;
            sb_q.push_back(e);
        end
        for (int i = 0; i < n; i++) begin
            tick();
            e   = sb_q.pop_front();
            obs = {tc, cc, cv, done, fault, idac, vdac};
            n_asserts++;
            assert (obs === e.exp) else begin
                n_fail++;
                $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; en = 1'b1; vbat = 8'd140; ibat = 8'd100; vtemp = 8'd50;
        tempmin = 8'd20; tempmax = 8'd100; vcutoff = 8'd150; vpreset = 8'd210;
        itc = 8'd10; icc = 8'd112; iend = 8'd11;
        #1;
        expect_n("reset_over_en", O_IDLE, 2);

        rst = 1'b0;
        expect_n("idle_qualify", O_IDLE, 3);
        expect_n("enter_tc", O_TC, 1);

        vbat = 8'd150;
        expect_n("tc_deb", O_TC, 3);
        expect_n("enter_cc", O_CC, 1);

        vbat = 8'd210;
        expect_n("cc_glitch_hi", O_CC, 3);
        vbat = 8'd200;
        expect_n("cc_glitch_lo", O_CC, 1);
        vbat = 8'd210;
        expect_n("cc_deb_cleared", O_CC, 3);
        expect_n("enter_cv", O_CV, 1);

        ibat = 8'd11;
        expect_n("cv_deb", O_CV, 3);
        expect_n("enter_done", O_DONE, 1);

        ibat = 8'd100;
        vbat = 8'd202;
        expect_n("done_hold_202", O_DONE, 6);
        vbat = 8'd201;
        expect_n("recharge_deb", O_DONE, 3);
        expect_n("recharge_cc", O_CC, 1);

        vtemp = 8'd101;
        expect_n("temp_fault", O_FAULT, 1);
        vtemp = 8'd50;
        expect_n("fault_deb", O_FAULT, 3);
        expect_n("fault_exit", O_IDLE, 1);
        expect_n("idle_to_cc_deb", O_IDLE, 3);
        expect_n("idle_to_cc", O_CC, 1);

        rst = 1'b1;
        expect_n("rst_mid_cc", O_IDLE, 1);
        rst = 1'b0;
        vbat = 8'd215;
        expect_n("post_rst_qualify", O_IDLE, 3);
        expect_n("idle_to_cv", O_CV, 1);

        en = 1'b0;
        expect_n("disable_cv", O_IDLE, 1);
        en = 1'b1;
        expect_n("reenable_qualify", O_IDLE, 3);
        expect_n("reenter_cv", O_CV, 1);
        expect_n("cv_timer_run", O_CV, 999);
        expect_n("cv_timeout", O_DONE, 1);

        en = 1'b0;
        vbat = 8'd100;
        expect_n("disable_done", O_IDLE, 1);
        en = 1'b1;
        expect_n("idle_to_tc_deb", O_IDLE, 3);
        expect_n("idle_to_tc", O_TC, 1);
        expect_n("tc_timer_run", O_TC, 499);
        expect_n("tc_timeout", O_FAULT, 1);
        expect_n("timeout_fault_deb", O_FAULT, 3);
        expect_n("timeout_fault_exit", O_IDLE, 1);

        vtemp = 8'd19;
        expect_n("idle_cold_deb", O_IDLE, 3);
        expect_n("idle_cold_fault", O_FAULT, 1);
        vtemp = 8'd100;
        expect_n("fault_tmax_deb", O_FAULT, 3);
        expect_n("fault_tmax_exit", O_IDLE, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule

// File: doc/batcharger_ctrl_fsm.md
BATCHARGER_CTRL_FSM -- requirements
Module: batcharger_ctrl_fsm

Interface
REQ-001 Parameter DEB, default 4: number of consecutive qualifying cycles required before any threshold-driven transition.
REQ-002 Parameter TTC_MAX, default 500: maximum cycles allowed in TC before FAULT.
REQ-003 Parameter TCV_MAX, default 1000: maximum cycles allowed in CV before DONE.
REQ-004 Parameter RECH, default 8: recharge hysteresis, in vbat LSBs, below vpreset.
REQ-005 clk  in  1  system clock; all logic is on the rising edge.
REQ-006 rst  in  1  reset; synchronous and active-high.
REQ-007 en  in  1  charger enable.
REQ-008 vbat  in  8  battery voltage ADC code; 1 LSB = 20 mV.
REQ-009 ibat  in  8  battery current ADC code; 1 LSB = 4 mA.
REQ-010 vtemp  in  8  battery temperature ADC code.
REQ-011 tempmin, tempmax  in  8 each  allowed temperature window, inclusive.
REQ-012 vcutoff, vpreset  in  8 each  TC/CC boundary and CC/CV boundary.
REQ-013 itc, icc, iend  in  8 each  trickle current code, constant-current code and end-of-charge current code.
REQ-014 tc, cc, cv  out  1 each  mode flags; at most one is high at a time.
REQ-015 idac  out  8  current setpoint code.
REQ-016 vdac  out  8  voltage setpoint code.
REQ-017 done  out  1  charge complete.
REQ-018 fault  out  1  temperature fault or trickle timeout.

Function
REQ-019 The FSM SHALL have six states: IDLE, TC, CC, CV, DONE and FAULT, held in a registered state variable.
REQ-020 All outputs SHALL be registered and decoded from the state, so they change on the same edge as the state.
REQ-021 Output decoding SHALL be:
- TC: tc=1, idac=itc, vdac=0.
- CC: cc=1, idac=icc, vdac=0.
- CV: cv=1, idac=icc (current limit), vdac=vpreset.
- DONE: done=1.
- FAULT: fault=1.
- Every output not listed for a state is 0.
REQ-022 Temperature is OK when tempmin <= vtemp <= tempmax (unsigned comparison).
REQ-023 Priority order, highest first: en=0 forces IDLE on the next edge; then temperature not OK forces FAULT on the next edge from any state except IDLE. Neither of these is debounced.
REQ-024 Leaving IDLE (en=1, temperature OK, condition held for DEB cycles):
- vbat < vcutoff: go to TC.
- vcutoff <= vbat < vpreset: go to CC.
- vbat >= vpreset: go to CV.
REQ-025 In IDLE with en=1 and temperature not OK, the FSM SHALL go to FAULT (debounced).
REQ-026 TC to CC when vbat >= vcutoff, debounced.
REQ-027 TC to FAULT when the TC timer reaches TTC_MAX-1 without exiting.
REQ-028 CC to CV when vbat >= vpreset, debounced.
REQ-029 CV to DONE when ibat <= iend (debounced), or when the CV timer reaches TCV_MAX-1 (not debounced).
REQ-030 DONE to CC when vbat < vpreset - RECH, debounced; the subtraction saturates at 0.
REQ-031 FAULT to IDLE when temperature is OK, debounced; the TC timeout fault also exits by this rule.
REQ-032 Debounce counter behaviour:
- 3 bits, saturating.
- Counts consecutive cycles in which the current state's exit condition is true.
- Clears to 0 when the condition is false and on every state change.
- The transition fires on the edge where the counter equals DEB-1 and the condition is still true, i.e. on the DEB-th qualifying edge.
REQ-033 Timer behaviour:
- One 16-bit timer.
- Clears on every state change.
- Increments each cycle in TC or CV.
- Held at 0 in all other states.
REQ-034 When several exit conditions are true on the same edge, the higher-priority rule of REQ-023 wins; in CV the timer expiry wins over the ibat condition.
REQ-035 Threshold comparisons SHALL be unsigned 8-bit and use no pipeline stage; the inputs are sampled directly every cycle.
REQ-036 A transition triggered by a condition held for DEB cycles ending at edge N SHALL have its outputs valid after edge N (latency = DEB edges from first qualifying sample).

Reset
REQ-037 On an edge with rst=1: state=IDLE, debounce counter=0, timer=0, and tc=cc=cv=done=fault=0, idac=0, vdac=0.
REQ-038 rst SHALL take precedence over en and every other input.
REQ-039 rst asserted mid-charge SHALL abort the charge in one edge, with no residual timer or debounce state.
REQ-040 After rst deasserts, the FSM SHALL require a full DEB-cycle qualification before leaving IDLE.

Verification
REQ-041 Full charge sequence.
- Stimulus: en=1, temperature OK, vcutoff=150, vpreset=210, itc=10, icc=112, iend=11; vbat ramps 140 -> 215.
- Response: TC with idac=10, then CC with idac=112, then CV with vdac=210. Reducing ibat to 10 gives done=1 after 4 edges.
- Each transition occurs exactly 4 edges after the threshold is crossed.
REQ-042 Debounce glitch.
- Stimulus: in CC, vbat=210 for 3 cycles, then 200.
- Response: stays in CC; debounce counter clears.
REQ-043 Temperature fault.
- Stimulus: vtemp rises above tempmax while in CC.
- Response: fault=1 and idac=0 on the next edge; IDLE after vtemp has been back in range for 4 cycles.
REQ-044 TC timeout.
- Stimulus: vbat held at 100 with vcutoff=150.
- Response: fault=1 exactly 500 edges after TC entry.
REQ-045 Recharge.
- Stimulus: in DONE, vbat falls to 201 with vpreset=210 and RECH=8.
- Response: CC (cc=1, idac=icc) after 4 edges; at vbat=202 the FSM stays in DONE.
REQ-046 Disable and reset.
- Stimulus: en=0 in CV; then rst=1 mid-CC.
- Response: IDLE with all outputs 0 on the next edge in both cases; cv timer reads 0 on re-entry.
